// File: rtl/pipe_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: merges ID hazards, multi-cycle EX ops and debug halt/step.
// state | meaning: RUN normal issue | MC multi-cycle op holds EX | HALT debug halt, fetch held | STEP single-step issue
module pipe_ctrl #(
    parameter int MC_LAT = 4,
    parameter int CW     = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_stall_i,
    input  logic       branch_i,
    input  logic       mc_start_i,
    input  logic       halt_req_i,
    input  logic       step_req_i,
    output logic       stall_if_o,
    output logic       stall_id_o,
    output logic       stall_ex_o,
    output logic       flush_ifid_o,
    output logic       flush_idex_o,
    output logic       bubble_mem_o,
    output logic       mc_busy_o,
    output logic       halted_o,
    output logic [1:0] state_o
);

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        MC   = 2'd1,
        HALT = 2'd2,
        STEP = 2'd3
    } state_t;

    localparam logic [CW-1:0] MC_LOAD = CW'(MC_LAT - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          issue;
    logic          stall_if_c, stall_id_c, stall_ex_c;
    logic          flush_ifid_c, flush_idex_c, bubble_mem_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        stall_if_c   = 1'b0;
        stall_id_c   = 1'b0;
        stall_ex_c   = 1'b0;
        flush_ifid_c = 1'b0;
        flush_idex_c = 1'b0;
        bubble_mem_c = 1'b0;
        issue        = ((state_q == RUN) || (state_q == STEP)) && !load_stall_i;

        unique case (state_q)
            RUN, STEP: begin
                // a load-use stall leaves branch operands stale, so the branch is not honoured
                if (load_stall_i) begin
                    stall_if_c   = 1'b1;
                    stall_id_c   = 1'b1;
                    flush_idex_c = 1'b1;
                end else if (branch_i) begin
                    flush_ifid_c = 1'b1;
                end

                if (issue && mc_start_i) begin
                    state_d = MC;
                    cnt_d   = MC_LOAD;
                end else if (state_q == STEP && load_stall_i) begin
                    state_d = STEP;
                end else if (halt_req_i) begin
                    state_d = HALT;
                end else begin
                    state_d = RUN;
                end
            end
            MC: begin
                stall_if_c   = 1'b1;
                stall_id_c   = 1'b1;
                stall_ex_c   = 1'b1;
                bubble_mem_c = 1'b1;
                if (cnt_q == CNT_ONE) begin
                    state_d = halt_req_i ? HALT : RUN;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            HALT: begin
                stall_if_c   = 1'b1;
                stall_id_c   = 1'b1;
                flush_idex_c = 1'b1;
                if (!halt_req_i) begin
                    state_d = RUN;
                end else if (step_req_i) begin
                    state_d = STEP;
                end
            end
            default: state_d = RUN;
        endcase
    end

    // everything reads as idle while reset is held
    assign stall_if_o   = stall_if_c   & ~rst;
    assign stall_id_o   = stall_id_c   & ~rst;
    assign stall_ex_o   = stall_ex_c   & ~rst;
    assign flush_ifid_o = flush_ifid_c & ~rst;
    assign flush_idex_o = flush_idex_c & ~rst;
    assign bubble_mem_o = bubble_mem_c & ~rst;
    assign mc_busy_o    = (state_q == MC)   & ~rst;
    assign halted_o     = (state_q == HALT) & ~rst;
    assign state_o      = rst ? 2'd0 : state_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: hand-computed output vectors checked one step at a time.
module tb_pipe_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load_stall_i = 1'b0;
    logic       branch_i = 1'b0;
    logic       mc_start_i = 1'b0;
    logic       halt_req_i = 1'b0;
    logic       step_req_i = 1'b0;
    logic       stall_if_o, stall_id_o, stall_ex_o;
    logic       flush_ifid_o, flush_idex_o, bubble_mem_o;
    logic       mc_busy_o, halted_o;
    logic [1:0] state_o;

    int checks = 0;
    int errors = 0;

    // {stall_if, stall_id, stall_ex, flush_ifid, flush_idex, bubble_mem, mc_busy, halted, state[1:0]}
    localparam logic [9:0] V_IDLE   = 10'b0000000000;
    localparam logic [9:0] V_LSTALL = 10'b1100100000;
    localparam logic [9:0] V_BRANCH = 10'b0001000000;
    localparam logic [9:0] V_MC     = 10'b1110011001;
    localparam logic [9:0] V_HALT   = 10'b1100100110;
    localparam logic [9:0] V_STEP   = 10'b0000000011;
    localparam logic [9:0] V_STEPLS = 10'b1100100011;

    pipe_ctrl #(.MC_LAT(4), .CW(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .load_stall_i (load_stall_i),
        .branch_i     (branch_i),
        .mc_start_i   (mc_start_i),
        .halt_req_i   (halt_req_i),
        .step_req_i   (step_req_i),
        .stall_if_o   (stall_if_o),
        .stall_id_o   (stall_id_o),
        .stall_ex_o   (stall_ex_o),
        .flush_ifid_o (flush_ifid_o),
        .flush_idex_o (flush_idex_o),
        .bubble_mem_o (bubble_mem_o),
        .mc_busy_o    (mc_busy_o),
        .halted_o     (halted_o),
        .state_o      (state_o)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [9:0] exp);
        logic [9:0] obs;
        #1;
        obs = {stall_if_o, stall_id_o, stall_ex_o, flush_ifid_o, flush_idex_o,
               bubble_mem_o, mc_busy_o, halted_o, state_o};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %b expected %b", tag, obs, exp);
        end
    endtask

    initial begin
        load_stall_i = 1'b1;
        chk("reset_outputs_zero", V_IDLE);
        cyc(); cyc();
        rst = 1'b0; load_stall_i = 1'b0;
        chk("after_reset_idle", V_IDLE);

        cyc(); load_stall_i = 1'b1;
        chk("load_stall_run", V_LSTALL);
        cyc(); load_stall_i = 1'b0;
        chk("load_stall_one_cycle", V_IDLE);

        cyc(); load_stall_i = 1'b1; branch_i = 1'b1;
        chk("branch_ignored_on_stall", V_LSTALL);
        cyc(); load_stall_i = 1'b0;
        chk("branch_alone_flush", V_BRANCH);
        cyc(); branch_i = 1'b0;
        chk("branch_cleared", V_IDLE);

        cyc(); load_stall_i = 1'b1; mc_start_i = 1'b1;
        chk("mc_start_under_stall", V_LSTALL);
        cyc(); load_stall_i = 1'b0; mc_start_i = 1'b0;
        chk("mc_start_dropped", V_IDLE);

        cyc(); mc_start_i = 1'b1;
        chk("mc_issue_cycle", V_IDLE);
        cyc(); mc_start_i = 1'b0; load_stall_i = 1'b1; branch_i = 1'b1;
        chk("mc_cycle1_ignores_id", V_MC);
        cyc(); load_stall_i = 1'b0; branch_i = 1'b0;
        chk("mc_cycle2", V_MC);
        cyc();
        chk("mc_cycle3", V_MC);
        cyc();
        chk("mc_exit_run", V_IDLE);

        mc_start_i = 1'b1;
        chk("mc2_issue", V_IDLE);
        cyc(); mc_start_i = 1'b0;
        chk("mc2_cycle1", V_MC);
        cyc(); halt_req_i = 1'b1;
        chk("mc2_halt_deferred", V_MC);
        cyc();
        chk("mc2_cycle3", V_MC);
        cyc();
        chk("mc2_exit_halt", V_HALT);

        step_req_i = 1'b1;
        chk("halt_step_pulse", V_HALT);
        cyc(); step_req_i = 1'b0; load_stall_i = 1'b1;
        chk("step_retry_stall", V_STEPLS);
        cyc(); load_stall_i = 1'b0;
        chk("step_issue", V_STEP);
        cyc();
        chk("step_back_to_halt", V_HALT);

        halt_req_i = 1'b0; step_req_i = 1'b1;
        chk("halt_release_with_step", V_HALT);
        cyc(); step_req_i = 1'b0;
        chk("release_wins_run", V_IDLE);

        step_req_i = 1'b1;
        chk("step_in_run_ignored", V_IDLE);
        cyc(); step_req_i = 1'b0;
        chk("still_run_after_step", V_IDLE);

        halt_req_i = 1'b1;
        chk("halt_req_current_advances", V_IDLE);
        cyc();
        chk("halt_applied_next", V_HALT);
        halt_req_i = 1'b0;
        cyc();
        chk("halt_released", V_IDLE);

        mc_start_i = 1'b1; halt_req_i = 1'b1;
        chk("mc_with_halt_issue", V_IDLE);
        cyc(); mc_start_i = 1'b0;
        chk("mc_priority_over_halt", V_MC);
        cyc(); cyc();
        chk("mc_halt_cycle3", V_MC);
        cyc();
        chk("mc_halt_exit", V_HALT);

        step_req_i = 1'b1;
        cyc(); step_req_i = 1'b0; mc_start_i = 1'b1;
        chk("step_mc_issue", V_STEP);
        cyc(); mc_start_i = 1'b0;
        chk("step_mc_cycle1", V_MC);
        cyc(); cyc();
        chk("step_mc_cycle3", V_MC);
        cyc();
        chk("step_mc_exit_halt", V_HALT);
        halt_req_i = 1'b0;
        cyc();
        chk("leave_halt_again", V_IDLE);

        mc_start_i = 1'b1;
        cyc(); mc_start_i = 1'b0;
        chk("rst_mc_cycle1", V_MC);
        cyc();
        chk("rst_mc_cnt2", V_MC);
        rst = 1'b1;
        chk("rst_mid_mc_zero", V_IDLE);
        cyc(); rst = 1'b0;
        chk("rst_release_run", V_IDLE);
        cyc();
        chk("rst_counter_abandoned", V_IDLE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
